div_seq: RTL
============

Name: div_seq

Overview:
- Multi-cycle restoring (radix-2) integer divider in the EX stage of the 5-stage MIPS pipeline.
- Executes DIV/DIVU.
- Operands come straight from the EX-stage forwarding muxes (srcA/srcB after forwarding).
- Produces HI (remainder) and LO (quotient), which the MEM-stage HI/LO write path consumes.
- Drives a stall request to the hazard unit while a division is in flight.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits; must be ≥2.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX-stage instruction is DIV/DIVU; operands valid this cycle
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- annul  in  1  flush of the EX-stage instruction (exception/branch); cancels operation
- a  in  WIDTH  dividend (forwarded srcA)
- b  in  WIDTH  divisor (forwarded srcB)
- stall  out  1  combinational stall request to hazard unit
- done  out  1  one-cycle pulse, result valid
- hi  out  WIDTH  remainder, registered
- lo  out  WIDTH  quotient, registered

Behaviour:
- States: IDLE, RUN, FIN. Iteration counter is $clog2(WIDTH)+1 bits.
- Reset (async, any state): state=IDLE, counter=0, done=0, hi=0, lo=0, internal operand/partial remainder registers=0.
- IDLE:
  - start=1 & annul=0 & b≠0 → latch |a|, |b| (magnitudes when signed_div=1, raw otherwise), record quotient sign (a[MSB]^b[MSB]) & signed_div and remainder sign a[MSB] & signed_div; counter=0; go to RUN.
  - start=1 & annul=0 & b=0 → latch a; go to FIN directly (divide-by-zero path).
  - start=0, or annul=1 → stay IDLE.
- RUN: one quotient bit per cycle, MSB first.
  - Shift {rem, dividend} left 1.
  - Trial-subtract divisor from the WIDTH+1-bit partial remainder; keep the difference and set the quotient bit when non-negative.
  - Counter increments; after iteration WIDTH (counter reaches WIDTH), go to FIN.
- FIN: lasts exactly one cycle, then IDLE.
  - Apply sign fixup: negate quotient if its sign flag is set; negate remainder if its sign flag is set.
  - Register results into hi/lo on the FIN→IDLE edge; done=1 in the following cycle (a registered pulse, one cycle).
- Latency:
  - start in cycle 0 → RUN cycles 1..WIDTH → FIN cycle WIDTH+1 → done=1 with valid hi/lo in cycle WIDTH+2.
  - Divide-by-zero: FIN in cycle 1, done in cycle 2.
- stall = (state==IDLE & start & ~annul) | (state==RUN) | (state==FIN).
  - stall is low in the done cycle, so the pipeline advances and MEM captures hi/lo.
- hi/lo hold their value until the next completed division; they are never updated by cancelled operations.
- Divide by zero: lo = all ones; hi = a (raw dividend), for both signed and unsigned.
- Signed overflow (most-negative / -1): lo = 0x80000000 (WIDTH=32), hi = 0. This falls out of the magnitude algorithm and must not be special-cased differently.
- Signed remainder takes the sign of the dividend; a zero remainder is never negated to a nonzero value.
- annul=1 in RUN or FIN:
  - Next state IDLE; hi/lo unchanged; done stays 0.
  - stall still follows the equation above in that cycle.
- start while not IDLE is ignored. The pipeline guarantees it is held, because the stall keeps the DIV in EX.
- start held high in the done cycle (same instruction still in EX) must NOT retrigger. The hazard unit deasserts start when stall falls. The block additionally ignores start in the cycle done=1.
- done is never asserted in two consecutive cycles.

Test Plan:
- Unsigned: start, signed_div=0, a=100, b=7 → stall high cycles 0..33, done=1 in cycle 34 only; lo=14, hi=2.
- Signed: a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with a=7, b=0xFFFFFFFE → lo=0xFFFFFFFD, hi=1.
- Divide by zero: a=0x12345678, b=0, both signed_div values → done in cycle 2; lo=0xFFFFFFFF, hi=0x12345678; stall high cycles 0..1 only.
- Overflow: signed a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. Same operands unsigned → lo=0, hi=0x80000000.
- Cancel/restart:
  - Complete 100/7 first.
  - Start 50/3, annul in cycle 10 → IDLE in cycle 11, no done, hi/lo still 2/14.
  - New start 50/3 → lo=16, hi=2 after full latency.
- Async reset mid-RUN (cycle 15) → immediately state IDLE, stall=0, done=0, hi=lo=0. A subsequent 9/3 gives lo=3, hi=0.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU in the EX stage.
// Produces quotient on lo and remainder on hi; holds a stall request while busy.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic             q_neg_reg, r_neg_reg, dz_reg;
    logic             done_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic             go;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] q_fix, r_fix;

    // A start in the done cycle is the same instruction still sitting in EX.
    assign go    = (state_reg == IDLE) & start & ~annul & ~done_reg;
    assign stall = go | (state_reg == RUN) | (state_reg == FIN);
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

    assign abs_a = (signed_div & a[WIDTH-1]) ? -a : a;
    assign abs_b = (signed_div & b[WIDTH-1]) ? -b : b;

    assign rem_sh = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
    assign diff   = {1'b0, rem_sh} - {2'b00, dsr_reg};
    assign q_bit  = ~diff[WIDTH+1];

    // Negating a zero remainder yields zero, so no extra guard is needed.
    assign q_fix = q_neg_reg ? -dvd_reg : dvd_reg;
    assign r_fix = r_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (go) state_next = (b == '0) ? FIN : RUN;
            end
            RUN: begin
                if (annul)                             state_next = IDLE;
                else if (cnt_reg == CW'(WIDTH - 1))    state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            dsr_reg   <= '0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
            dz_reg    <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        cnt_reg <= '0;
                        rem_reg <= '0;
                        if (b == '0) begin
                            // Divide-by-zero keeps the raw dividend for hi.
                            dvd_reg   <= a;
                            dsr_reg   <= '0;
                            q_neg_reg <= 1'b0;
                            r_neg_reg <= 1'b0;
                            dz_reg    <= 1'b1;
                        end else begin
                            dvd_reg   <= abs_a;
                            dsr_reg   <= abs_b;
                            q_neg_reg <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
                            r_neg_reg <= a[WIDTH-1] & signed_div;
                            dz_reg    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= q_bit ? diff[WIDTH:0] : rem_sh;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIN: begin
                    if (!annul) begin
                        done_reg <= 1'b1;
                        if (dz_reg) begin
                            lo_reg <= '1;
                            hi_reg <= dvd_reg;
                        end else begin
                            lo_reg <= q_fix;
                            hi_reg <= r_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
